fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the two-port, two-stage forwarding selector: N read ports, M forwarding stages, plus hazard detection.
- Adds x0 suppression, load-use stall, a scoreboard for an out-of-pipe multi-cycle unit (MUL/DIV) with a write-back bypass, and a stall-cycle performance counter.
- Sits beside the ID/EX boundary. It drives operand-mux selects to EX, a stall to IF/ID, and a bubble into EX.

Parameters:
- NUM_RD_PORTS, 2, number of source-operand read ports checked.
- NUM_FWD_STAGES, 2, forwarding sources; index 0 is youngest (MEM), index M-1 oldest (WB).
- REG_AW, 5, register address width; register 0 is hardwired zero.
- MAX_MC_OUT, 4, max outstanding multi-cycle ops (>=1).
- PERF_W, 32, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NUM_RD_PORTS*REG_AW  ID source addresses, port p at bits [p*REG_AW +: REG_AW]
- rd_used  in  NUM_RD_PORTS  port p actually reads a register
- fwd_wr_addr  in  NUM_FWD_STAGES*REG_AW  destination per stage
- fwd_wr_en  in  NUM_FWD_STAGES  stage writes a register
- ex_rd  in  REG_AW  destination of instruction in EX
- ex_is_load  in  1  EX instruction is a load with a register write
- id_is_mc  in  1  ID instruction issues to the multi-cycle unit
- id_mc_rd  in  REG_AW  its destination
- mc_wb_valid  in  1  multi-cycle unit writes back this cycle
- mc_wb_rd  in  REG_AW  its destination
- fwd_sel  out  NUM_RD_PORTS*SEL_W  per-port select; SEL_W=$clog2(NUM_FWD_STAGES+2)
- stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  inject NOP into ID/EX
- mc_outstanding  out  $clog2(MAX_MC_OUT+1)  count of pending multi-cycle ops
- stall_cnt  out  PERF_W  cycles with stall_id=1

Behaviour:
- Select encoding per port:
  - 0 = register file.
  - k+1 = stage k.
  - NUM_FWD_STAGES+1 = multi-cycle write-back bypass.
- Select priority, combinational:
  - Lowest stage index wins.
  - Then mc bypass (mc_wb_valid and mc_wb_rd match).
  - Else 0.
  - Address 0 or rd_used=0 always selects 0.
- Load-use hazard: ex_is_load, ex_rd!=0, and ex_rd matches any used port -> stall_id=1, bubble_ex=1 for that cycle. The hazard clears by itself the next cycle, when the load reaches MEM.
- Scoreboard: register pending[2**REG_AW], cleared on rst.
  - Issue occurs when id_is_mc=1, stall_id=0 and id_mc_rd!=0. Issue sets pending[id_mc_rd] at the next edge.
  - mc_wb_valid clears pending[mc_wb_rd] at the next edge.
  - Same register set and cleared in one cycle: set wins, because the issuing op is younger.
- Scoreboard stall (RAW): a used port whose address is pending and not bypassed this cycle.
- Scoreboard stall (WAW): id_is_mc with pending[id_mc_rd]=1.
- Scoreboard stall (structural): id_is_mc with mc_outstanding==MAX_MC_OUT, unless mc_wb_valid this cycle.
- Each scoreboard stall asserts stall_id=1 and bubble_ex=1.
- mc_outstanding update: +1 on issue, -1 on mc_wb_valid, unchanged when both occur. It never wraps. mc_wb_valid at count 0 is ignored and raises an SVA assertion.
- stall_cnt increments each cycle stall_id=1 and saturates at all-ones.
- Reset values:
  - All pending bits 0, mc_outstanding 0, stall_cnt 0.
  - Outputs stall_id, bubble_ex and fwd_sel follow the cleared state: 0 with inputs idle.
- Reset mid-operation drops all outstanding ops. The multi-cycle unit is reset by the same rst.
- stall_id and bubble_ex are combinational from inputs and registered state; there are no added registered outputs.

Decomposition:
- Package fwd_hazard_pkg holds:
  - the select encodings (FWD_SEL_RF, FWD_SEL_MCBYP);
  - a function computing SEL_W;
  - the typedef for a register address.
- Sub-module mc_scoreboard holds the pending vector, the outstanding counter, the lookup and the issue-legality output.
- The top holds the per-port priority select, the load-use check and the perf counter.

Test Plan:
- Ports x5 and x6. MEM writes x5 and WB writes x5 -> sel port0=1 (MEM wins). WB writes x6 -> sel port1=2. Nothing writes -> 0.
- Port reads x0 while MEM writes x0 -> sel=0, no stall.
- EX load to x7, ID uses x7 -> stall_id=1 and bubble_ex=1 for exactly 1 cycle. stall_cnt increments by 1.
- Issue DIV to x9; 3 cycles later ID reads x9 with no write-back -> stall every cycle. When mc_wb_valid with rd=9 arrives -> sel=3 (bypass), no stall, and pending[9]=0 the following cycle.
- Issue 4 ops to x1..x4 (MAX_MC_OUT=4), then a 5th -> stall. Same cycle as a write-back -> 5th issues and count stays 4.
- Issue to x8 while x8 pending -> WAW stall. Assert rst mid-stall -> next cycle count=0 and no stall.

Source files
------------

// File: rtl/fwd_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_pkg
// Description : Shared encodings, helpers and types for the forwarding and
//               hazard unit and its multi-cycle scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_hazard_pkg;

    // Operand select value that picks the register file.
    localparam int FWD_SEL_RF = 0;

    // Register address width of the default configuration.
    localparam int REG_AW_DEF = 5;

    // Register address of the default configuration.
    typedef logic [REG_AW_DEF-1:0] reg_addr_t;

    // Select width: register file, one code per stage, plus the mc bypass.
    function automatic int fwd_sel_width(input int num_stages);
        return $clog2(num_stages + 2);
    endfunction

    // Select value for the multi-cycle write-back bypass (FWD_SEL_MCBYP);
    // it sits directly above the last forwarding stage code.
    function automatic int fwd_sel_mcbyp(input int num_stages);
        return num_stages + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_unit_mc_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : mc_scoreboard
// Description : Pending-destination scoreboard for the out-of-pipe multi-cycle
//               unit. Tracks outstanding ops and flags RAW, WAW and structural
//               hazards for the instruction in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_scoreboard
    import fwd_hazard_pkg::*;
#(
    parameter int NUM_RD_PORTS = 2,
    parameter int REG_AW       = 5,
    parameter int MAX_MC_OUT   = 4,
    localparam int CNT_W       = $clog2(MAX_MC_OUT + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] i_rd_addr,
    input  logic [NUM_RD_PORTS-1:0]        i_rd_used,
    input  logic                           i_id_is_mc,
    input  logic [REG_AW-1:0]              i_id_mc_rd,
    input  logic                           i_mc_wb_valid,
    input  logic [REG_AW-1:0]              i_mc_wb_rd,
    input  logic                           i_hold,
    output logic                           o_sb_stall,
    output logic [CNT_W-1:0]               o_mc_outstanding
);

    localparam int              c_NUM_REGS = 2 ** REG_AW;
    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_MC_OUT);

    logic [c_NUM_REGS-1:0] r_pending;
    logic [CNT_W-1:0]      r_count;
    logic [c_NUM_REGS-1:0] w_pending_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  w_raw;
    logic                  w_waw;
    logic                  w_struct;
    logic                  w_issue;
    logic                  w_wb_eff;

    // A write-back with nothing outstanding is meaningless and is dropped.
    assign w_wb_eff = i_mc_wb_valid && (r_count != '0);

    // RAW lookup: a used source that is still pending and not bypassed now.
    always_comb begin
        w_raw = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (i_rd_used[p] && (i_rd_addr[p*REG_AW +: REG_AW] != '0) &&
                r_pending[i_rd_addr[p*REG_AW +: REG_AW]] &&
                !(i_mc_wb_valid && (i_mc_wb_rd == i_rd_addr[p*REG_AW +: REG_AW]))) begin
                w_raw = 1'b1;
            end
        end
    end

    // WAW and structural checks on the op trying to issue from ID.
    always_comb begin
        w_waw    = i_id_is_mc && r_pending[i_id_mc_rd];
        w_struct = i_id_is_mc && (r_count == c_MAX_CNT) && !i_mc_wb_valid;
    end

    assign o_sb_stall = w_raw || w_waw || w_struct;

    // An op issues only when nothing holds ID; writes to x0 are never tracked.
    assign w_issue = i_id_is_mc && !o_sb_stall && !i_hold && (i_id_mc_rd != '0);

    // Next pending vector: set is applied after clear so the younger issue wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wb_eff) begin
            w_pending_nxt[i_mc_wb_rd] = 1'b0;
        end
        if (w_issue) begin
            w_pending_nxt[i_id_mc_rd] = 1'b1;
        end
    end

    // Outstanding count: issue and write-back in one cycle cancel out.
    always_comb begin
        w_count_nxt = r_count;
        if (w_issue && !w_wb_eff && (r_count != c_MAX_CNT)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_issue && w_wb_eff) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Scoreboard state register; reset drops every outstanding op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign o_mc_outstanding = r_count;

    // A write-back with no outstanding op points at a broken multi-cycle unit.
    a_no_wb_when_empty : assert property (@(posedge clk) disable iff (rst)
        !(i_mc_wb_valid && (r_count == '0)));

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_unit
// Description : Operand forwarding select for N read ports over M stages plus
//               mc write-back bypass, load-use and scoreboard stall generation,
//               and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int NUM_RD_PORTS   = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int REG_AW         = 5,
    parameter int MAX_MC_OUT     = 4,
    parameter int PERF_W         = 32,
    localparam int SEL_W         = fwd_sel_width(NUM_FWD_STAGES),
    localparam int CNT_W         = $clog2(MAX_MC_OUT + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RD_PORTS*REG_AW-1:0]   i_rd_addr,
    input  logic [NUM_RD_PORTS-1:0]          i_rd_used,
    input  logic [NUM_FWD_STAGES*REG_AW-1:0] i_fwd_wr_addr,
    input  logic [NUM_FWD_STAGES-1:0]        i_fwd_wr_en,
    input  logic [REG_AW-1:0]                i_ex_rd,
    input  logic                             i_ex_is_load,
    input  logic                             i_id_is_mc,
    input  logic [REG_AW-1:0]                i_id_mc_rd,
    input  logic                             i_mc_wb_valid,
    input  logic [REG_AW-1:0]                i_mc_wb_rd,
    output logic [NUM_RD_PORTS*SEL_W-1:0]    o_fwd_sel,
    output logic                             o_stall_id,
    output logic                             o_bubble_ex,
    output logic [CNT_W-1:0]                 o_mc_outstanding,
    output logic [PERF_W-1:0]                o_stall_cnt
);

    localparam logic [SEL_W-1:0] c_SEL_RF    = SEL_W'(FWD_SEL_RF);
    localparam logic [SEL_W-1:0] c_SEL_MCBYP = SEL_W'(fwd_sel_mcbyp(NUM_FWD_STAGES));

    logic              w_load_use;
    logic              w_sb_stall;
    logic              w_stall;
    logic [PERF_W-1:0] r_stall_cnt;

    // Per-port operand select: youngest matching stage, then mc bypass, else RF.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [REG_AW-1:0] w_addr;
        logic [SEL_W-1:0]  w_sel;

        assign w_addr = i_rd_addr[p*REG_AW +: REG_AW];

        // Scan oldest to youngest so the lowest stage index overrides last.
        always_comb begin
            w_sel = c_SEL_RF;
            if (i_rd_used[p] && (w_addr != '0)) begin
                if (i_mc_wb_valid && (i_mc_wb_rd == w_addr)) begin
                    w_sel = c_SEL_MCBYP;
                end
                for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                    if (i_fwd_wr_en[k] && (i_fwd_wr_addr[k*REG_AW +: REG_AW] == w_addr)) begin
                        w_sel = SEL_W'(k + 1);
                    end
                end
            end
        end

        assign o_fwd_sel[p*SEL_W +: SEL_W] = w_sel;
    end

    // Load-use: the loaded value is not available until the load reaches MEM.
    always_comb begin
        w_load_use = 1'b0;
        if (i_ex_is_load && (i_ex_rd != '0)) begin
            for (int p = 0; p < NUM_RD_PORTS; p++) begin
                if (i_rd_used[p] && (i_rd_addr[p*REG_AW +: REG_AW] == i_ex_rd)) begin
                    w_load_use = 1'b1;
                end
            end
        end
    end

    mc_scoreboard #(
        .NUM_RD_PORTS (NUM_RD_PORTS),
        .REG_AW       (REG_AW),
        .MAX_MC_OUT   (MAX_MC_OUT)
    ) u_mc_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .i_rd_addr        (i_rd_addr),
        .i_rd_used        (i_rd_used),
        .i_id_is_mc       (i_id_is_mc),
        .i_id_mc_rd       (i_id_mc_rd),
        .i_mc_wb_valid    (i_mc_wb_valid),
        .i_mc_wb_rd       (i_mc_wb_rd),
        .i_hold           (w_load_use),
        .o_sb_stall       (w_sb_stall),
        .o_mc_outstanding (o_mc_outstanding)
    );

    assign w_stall     = w_load_use || w_sb_stall;
    assign o_stall_id  = w_stall;
    assign o_bubble_ex = w_stall;

    // Stall-cycle performance counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
